// File: rtl/ind_fifo_sched.sv
// ---------------------------------------------------------------------------
// sys_arr_pkg : operand widths shared by the systolic-array operand path.
//
// ind_fifo_sched : controller for the bank of N sparse-operand input FIFOs
// on one edge of the systolic array. Compressed elements arriving from the
// operand memory streamer are steered into the FIFO named by in_sel. The
// block tracks per-lane occupancy and end-of-row status, issues lock-step
// shift beats to the array, and pulses done once a whole pass has drained.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-high reset
//   start           begin a pass (only honoured while idle)
//   in_valid/ready  element handshake from the streamer
//   in_sel          destination lane of the offered element
//   in_val/ind/end  element value, index and end-of-row flag
//   fifo_load       one-hot load strobe into the FIFO bank
//   fifo_load_*     value/index/end buses broadcast to every FIFO
//   fifo_shift      per-lane shift strobe into the FIFO bank
//   arr_ready       array accepts a beat this cycle
//   arr_valid       a beat is presented and shifted this cycle
//   lane_valid      lanes carrying real data in this beat
//   busy            a pass is in progress
//   done            one-cycle pass-complete pulse
// ---------------------------------------------------------------------------
package sys_arr_pkg;
  localparam int DW  = 8;
  localparam int IND = 4;
endpackage

module ind_fifo_sched
  import sys_arr_pkg::*;
#(
  parameter int N     = 4,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [$clog2(N)-1:0] in_sel,
  input  logic [DW-1:0]        in_val,
  input  logic [IND-1:0]       in_ind,
  input  logic                 in_end,
  output logic [N-1:0]         fifo_load,
  output logic [DW-1:0]        fifo_load_vals,
  output logic [IND-1:0]       fifo_load_inds,
  output logic                 fifo_load_ends,
  output logic [N-1:0]         fifo_shift,
  input  logic                 arr_ready,
  output logic                 arr_valid,
  output logic [N-1:0]         lane_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt      [N];
  logic [CW-1:0] cnt_next [N];
  logic [N-1:0]  fin;
  logic [N-1:0]  fin_next;
  logic [N-1:0]  nonempty;
  logic          accept;
  logic          eligible;
  logic          shift_en;
  logic          all_empty_next;

  // The data buses are shared by every FIFO; only the one-hot load strobe
  // decides which FIFO actually captures them.
  assign fifo_load_vals = in_val;
  assign fifo_load_inds = in_ind;
  assign fifo_load_ends = in_end;

  // Handshake, beat generation and next-occupancy computation. A lane that
  // has seen its end element and run dry only contributes a bubble, so it
  // never holds back the lanes that still have data. A beat is only issued
  // when at least one lane carries real data. A full lane refuses input
  // even if it is about to shift; there is no full-and-shift bypass.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      nonempty[i] = (cnt[i] != '0);
    end

    in_ready = (state == S_RUN) && !fin[in_sel] && (cnt[in_sel] != CW'(DEPTH));
    accept   = in_valid && in_ready;

    fifo_load = '0;
    if (accept) begin
      fifo_load[in_sel] = 1'b1;
    end

    eligible   = (&(nonempty | fin)) && (|nonempty);
    shift_en   = ((state == S_RUN) || (state == S_DRAIN)) && eligible && arr_ready;
    fifo_shift = shift_en ? nonempty : '0;
    arr_valid  = shift_en;
    lane_valid = fifo_shift;

    fin_next = fin | (in_end ? fifo_load : '0);

    all_empty_next = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = cnt[i] + CW'(fifo_load[i]) - CW'(fifo_shift[i]);
      if (cnt_next[i] != '0) begin
        all_empty_next = 1'b0;
      end
    end
  end

  // Pass sequencer together with the occupancy and end-of-row trackers.
  // Idle keeps the trackers cleared so every pass starts from scratch. The
  // move to DRAIN looks at fin_next so an end element accepted this cycle
  // already counts; the move to DONE looks at cnt_next so the final shift
  // is seen in the same cycle. busy and done are kept as flops that follow
  // the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fin   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          fin <= '0;
          for (int i = 0; i < N; i++) begin
            cnt[i] <= '0;
          end
          if (start) begin
            state <= S_RUN;
            busy  <= 1'b1;
          end
        end
        S_RUN: begin
          fin <= fin_next;
          for (int i = 0; i < N; i++) begin
            cnt[i] <= cnt_next[i];
          end
          if (&fin_next) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          for (int i = 0; i < N; i++) begin
            cnt[i] <= cnt_next[i];
          end
          if (all_empty_next) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ind_fifo_sched.sv
// ---------------------------------------------------------------------------
// tb_ind_fifo_sched : scoreboard bench for ind_fifo_sched.
//
// The main process drives directed passes and pushes the expected beat
// masks and, per lane, the elements it hands over. A negedge monitor plays
// the part of the FIFO bank (capturing loads, popping on shifts) and checks
// every presented beat against the scoreboard queues.
// ---------------------------------------------------------------------------
module tb_ind_fifo_sched;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int DW    = sys_arr_pkg::DW;
  localparam int IND   = sys_arr_pkg::IND;
  localparam int EW    = DW + IND + 1;
  localparam int QD    = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     in_sel;
  logic [DW-1:0]  in_val;
  logic [IND-1:0] in_ind;
  logic           in_end;
  logic [N-1:0]   fifo_load;
  logic [DW-1:0]  fifo_load_vals;
  logic [IND-1:0] fifo_load_inds;
  logic           fifo_load_ends;
  logic [N-1:0]   fifo_shift;
  logic           arr_ready;
  logic           arr_valid;
  logic [N-1:0]   lane_valid;
  logic           busy;
  logic           done;

  ind_fifo_sched #(.N(N), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sel         (in_sel),
    .in_val         (in_val),
    .in_ind         (in_ind),
    .in_end         (in_end),
    .fifo_load      (fifo_load),
    .fifo_load_vals (fifo_load_vals),
    .fifo_load_inds (fifo_load_inds),
    .fifo_load_ends (fifo_load_ends),
    .fifo_shift     (fifo_shift),
    .arr_ready      (arr_ready),
    .arr_valid      (arr_valid),
    .lane_valid     (lane_valid),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int           checks     = 0;
  int           failures   = 0;
  int           done_count = 0;
  logic [N-1:0] exp_mask_q [$];
  logic [EW-1:0] exp_data  [N][QD];
  int           exp_head   [N];
  int           exp_tail   [N];
  logic [EW-1:0] bank      [N][DEPTH+1];
  int           bank_size  [N];
  logic [N-1:0] mon_mask;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic failNow(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s", name);
  endtask

  // Model of the FIFO bank plus the beat checker.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        bank_size[i] = 0;
        exp_head[i]  = exp_tail[i];
      end
      exp_mask_q.delete();
    end else begin
      if (done) done_count++;
      if (arr_valid) begin
        if (exp_mask_q.size() == 0) begin
          failNow("unexpected_beat");
        end else begin
          mon_mask = exp_mask_q.pop_front();
          checkOutput("lane_valid", 32'(lane_valid), 32'(mon_mask));
        end
        checkOutput("shift_vs_lane_valid", 32'(fifo_shift), 32'(lane_valid));
        for (int i = 0; i < N; i++) begin
          if (fifo_shift[i]) begin
            if (bank_size[i] == 0) begin
              failNow($sformatf("lane%0d_underflow", i));
            end else begin
              if (exp_head[i] == exp_tail[i]) begin
                failNow($sformatf("lane%0d_no_expected_data", i));
              end else begin
                checkOutput($sformatf("lane%0d_data", i), 32'(bank[i][0]),
                            32'(exp_data[i][exp_head[i] % QD]));
                exp_head[i]++;
              end
              for (int k = 0; k < DEPTH; k++) bank[i][k] = bank[i][k+1];
              bank_size[i]--;
            end
          end
        end
      end else if (fifo_shift != '0) begin
        failNow("shift_without_arr_valid");
      end
      if (fifo_load != '0) begin
        if ($countones(fifo_load) != 1) failNow("load_not_onehot");
        for (int i = 0; i < N; i++) begin
          if (fifo_load[i]) begin
            if (bank_size[i] == DEPTH) begin
              failNow($sformatf("lane%0d_overflow", i));
            end else begin
              bank[i][bank_size[i]] = {fifo_load_vals, fifo_load_inds, fifo_load_ends};
              bank_size[i]++;
            end
          end
        end
      end
    end
  end

  // Offer one element and hold it until accepted (bounded).
  task automatic applyStimulus(input int sel, input logic [DW-1:0] v, input logic endf);
    logic [IND-1:0] ix;
    logic [N-1:0]   oh;
    bit             ok;
    ix = ~v[IND-1:0];
    oh = '0;
    oh[sel] = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'(sel);
    in_val   = v;
    in_ind   = ix;
    in_end   = endf;
    ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        checkOutput("load_strobe", 32'(fifo_load), 32'(oh));
        exp_data[sel][exp_tail[sel] % QD] = {v, ix, endf};
        exp_tail[sel]++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_end   = 1'b0;
    if (!ok) failNow("accept_timeout");
  endtask

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    checkOutput("busy_before_start", 32'(busy), 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", 32'(busy), 1);
    @(posedge clk); #1;
  endtask

  task automatic waitDone(input string name);
    int base;
    bit seen;
    base = done_count;
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) begin
      failNow({name, "_done_timeout"});
    end else begin
      @(negedge clk); #1;
      checkOutput({name, "_done_pulses"}, 32'(done_count - base), 1);
      checkOutput({name, "_busy_fall"}, 32'(busy), 0);
      checkOutput({name, "_beats_left"}, 32'(exp_mask_q.size()), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({name, "_fifo_load"}, 32'(fifo_load), 0);
    checkOutput({name, "_fifo_shift"}, 32'(fifo_shift), 0);
    checkOutput({name, "_arr_valid"}, 32'(arr_valid), 0);
    checkOutput({name, "_lane_valid"}, 32'(lane_valid), 0);
    checkOutput({name, "_busy"}, 32'(busy), 0);
    checkOutput({name, "_done"}, 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      exp_head[i]  = 0;
      exp_tail[i]  = 0;
      bank_size[i] = 0;
    end
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_sel = '0;
    in_val = '0; in_ind = '0; in_end = 1'b0; arr_ready = 1'b0;

    // Power-up reset
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    checkResetOutputs("por");
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Dense pass: three elements per lane
    $display("[TB] dense pass");
    arr_ready = 1'b1;
    repeat (3) exp_mask_q.push_back(4'b1111);
    doStart();
    for (int j = 0; j < 3; j++)
      for (int l = 0; l < N; l++)
        applyStimulus(l, DW'(8'h10 + 4*j + l), j == 2);
    waitDone("dense");

    // Ragged rows: lane l carries l+1 elements
    $display("[TB] ragged pass");
    exp_mask_q.push_back(4'b1111);
    exp_mask_q.push_back(4'b1110);
    exp_mask_q.push_back(4'b1100);
    exp_mask_q.push_back(4'b1000);
    doStart();
    for (int j = 0; j < 4; j++)
      for (int l = 0; l < N; l++)
        if (l >= j) applyStimulus(l, DW'(8'h40 + 4*j + l), j == l);
    waitDone("ragged");

    // Backpressure with lane 2 filled, then simultaneous load and shift
    $display("[TB] backpressure pass");
    arr_ready = 1'b0;
    doStart();
    applyStimulus(0, 8'h80, 1'b1);
    applyStimulus(1, 8'h81, 1'b1);
    applyStimulus(3, 8'h83, 1'b0);
    for (int k = 0; k < DEPTH; k++) applyStimulus(2, DW'(8'h90 + k), 1'b0);
    in_sel = 2'd2;
    @(negedge clk);
    checkOutput("ready_full_lane", 32'(in_ready), 0);
    #1 checkOutput("lane2_full", 32'(bank_size[2]), DEPTH);
    @(posedge clk); #1;
    in_sel = 2'd3;
    @(negedge clk);
    checkOutput("ready_open_lane", 32'(in_ready), 1);
    @(posedge clk); #1;
    exp_mask_q.push_back(4'b1111);
    arr_ready = 1'b1;
    in_sel = 2'd2;
    @(negedge clk);
    checkOutput("ready_full_during_beat", 32'(in_ready), 0);
    @(posedge clk); #1;
    arr_ready = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_beat", 32'(in_ready), 1);
    #1 checkOutput("lane2_cnt_after_beat", 32'(bank_size[2]), 3);
    @(posedge clk); #1;
    applyStimulus(3, 8'hA0, 1'b0);
    applyStimulus(3, 8'hA1, 1'b0);
    @(negedge clk); #1;
    checkOutput("lane3_cnt_before", 32'(bank_size[3]), 2);
    @(posedge clk); #1;
    exp_mask_q.push_back(4'b1100);
    in_valid = 1'b1; in_sel = 2'd3; in_val = 8'hA2; in_ind = ~4'h2; in_end = 1'b0;
    arr_ready = 1'b1;
    exp_data[3][exp_tail[3] % QD] = {8'hA2, ~4'h2, 1'b0};
    exp_tail[3]++;
    @(negedge clk);
    checkOutput("simul_ready", 32'(in_ready), 1);
    checkOutput("simul_load", 32'(fifo_load), 32'(4'b1000));
    checkOutput("simul_shift", 32'(fifo_shift), 32'(4'b1100));
    #1 checkOutput("simul_lane3_cnt", 32'(bank_size[3]), 2);
    checkOutput("simul_lane2_cnt", 32'(bank_size[2]), 2);
    @(posedge clk); #1;
    in_valid = 1'b0; arr_ready = 1'b0;
    applyStimulus(2, 8'h94, 1'b1);
    applyStimulus(3, 8'hA3, 1'b1);
    repeat (3) exp_mask_q.push_back(4'b1100);
    arr_ready = 1'b1;
    waitDone("backpressure");

    // Writes to a finished lane stall and are re-offered next pass
    $display("[TB] finished-lane pass");
    arr_ready = 1'b0;
    doStart();
    applyStimulus(1, 8'hB1, 1'b1);
    in_valid = 1'b1; in_sel = 2'd1; in_val = 8'hC1; in_ind = ~4'h1; in_end = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("finished_lane_ready", 32'(in_ready), 0);
      checkOutput("finished_lane_load", 32'(fifo_load), 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_end = 1'b0;
    applyStimulus(0, 8'hB0, 1'b1);
    applyStimulus(2, 8'hB2, 1'b1);
    applyStimulus(3, 8'hB3, 1'b1);
    exp_mask_q.push_back(4'b1111);
    arr_ready = 1'b1;
    waitDone("finished_lane");
    exp_mask_q.push_back(4'b1111);
    doStart();
    applyStimulus(0, 8'hC0, 1'b1);
    applyStimulus(1, 8'hC1, 1'b1);
    applyStimulus(2, 8'hC2, 1'b1);
    applyStimulus(3, 8'hC3, 1'b1);
    waitDone("resumed_lane");

    // Reset during DRAIN with data still queued
    $display("[TB] reset mid-drain");
    arr_ready = 1'b0;
    doStart();
    for (int l = 0; l < N; l++) applyStimulus(l, DW'(8'hD0 + l), 1'b1);
    @(negedge clk);
    checkOutput("drain_busy", 32'(busy), 1);
    checkOutput("drain_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; arr_ready = 1'b1; in_valid = 1'b1; in_sel = 2'd0;
    @(negedge clk);
    checkResetOutputs("midrst");
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_mask_q.push_back(4'b1111);
    doStart();
    for (int l = 0; l < N; l++) applyStimulus(l, DW'(8'hE0 + l), 1'b1);
    waitDone("after_reset");

    checkOutput("final_beats_left", 32'(exp_mask_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ind_fifo_sched.md
# ind_fifo_sched

Controller for the bank of N sparse-operand input FIFOs feeding one edge of the systolic array; each FIFO holds value, index and end-of-row flag lanes with a single load and a single shift strobe. The block accepts a stream of compressed elements tagged with a destination lane and steers each into its FIFO. It tracks per-FIFO occupancy and end-of-row status. It issues lock-step shift beats to the array, then reports pass completion. It sits between the operand memory streamer and the FIFO bank.

## Interface
- N, 4, number of FIFOs / array lanes (≥2)
- DEPTH, 4, entries per FIFO (≥2)
- DW, from sys_arr_pkg, value width
- IND, from sys_arr_pkg, index width
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a pass; honoured only in IDLE
- in_valid  in  1  element offered
- in_ready  out  1  element accepted when in_valid&&in_ready
- in_sel  in  $clog2(N)  destination lane
- in_val  in  DW  element value
- in_ind  in  IND  element index
- in_end  in  1  last element of this lane's row
- fifo_load  out  N  one-hot load strobe
- fifo_load_vals  out  DW  broadcast value (=in_val)
- fifo_load_inds  out  IND  broadcast index (=in_ind)
- fifo_load_ends  out  1  broadcast end flag (=in_end)
- fifo_shift  out  N  per-lane shift strobe
- arr_ready  in  1  array consumes a beat this cycle
- arr_valid  out  1  a beat is presented/shifted this cycle
- lane_valid  out  N  lanes carrying real data in this beat
- busy  out  1  state != IDLE
- done  out  1  one-cycle pass-complete pulse

## Operation
- State: cnt[i] (0..DEPTH), fin[i] (end element loaded), FSM {IDLE, RUN, DRAIN, DONE}.
- IDLE: cnt, fin cleared; start → RUN.
- in_ready = (state==RUN) && !fin[in_sel] && cnt[in_sel]!=DEPTH; no full-and-shift bypass.
- Accept: fifo_load = onehot(in_sel), otherwise 0; load data buses pass through combinationally; fin[in_sel] set if in_end.
- Beat eligibility: every lane has cnt[i]>0 or fin[i], and at least one cnt[i]>0.
- shift_en = (RUN or DRAIN) && eligibility && arr_ready; fifo_shift[i] = shift_en && cnt[i]>0; arr_valid = shift_en; lane_valid[i] = fifo_shift[i].
- Finished, empty lanes emit bubbles; they never stall the other lanes.
- cnt[i] next = cnt[i] + fifo_load[i] − fifo_shift[i]; a simultaneous load and shift on one lane leaves cnt unchanged.
- RUN → DRAIN when all fin are set, counting an end accepted this cycle.
- DRAIN → DONE when all cnt==0 after this cycle's shifts.
- DONE: done=1 for one cycle → IDLE.
- start outside IDLE is ignored. in_valid outside RUN, or to a finished lane, stalls; it is never dropped.

## Timing
- Reset values: in_ready=0, fifo_load=0, fifo_shift=0, arr_valid=0, lane_valid=0, busy=0, done=0; cnt=0, fin=0, FSM=IDLE.
- Reset mid-pass returns to IDLE at the next edge. The FIFO bank shares rst and is cleared by the same edge.
- Load and shift strobes are combinational in the handshake cycle. The FIFO captures them at that edge; cnt and fin update at the same edge.
- An element loaded at edge k is earliest eligible for a shift in cycle k+1.
- start at edge k → busy=1 from cycle k+1.
- Last shift at edge k → DONE in cycle k+1 (done=1) → IDLE in cycle k+2.
- Empty row: a lane whose first element carries in_end holds one real entry. Zero-length rows are not representable.

## Test plan
- Dense pass, N=4, DEPTH=4. Each lane gets 3 elements, the last with in_end; arr_ready held 1. Required: exactly 3 beats with lane_valid=4'b1111, then done pulses once and busy falls the following cycle.
- Ragged rows of lengths 1, 2, 3, 4 on lanes 0–3. Required: 4 beats with lane_valid 1111, 1110, 1100, 1000, and shifted values/indices match input order per lane.
- Backpressure: fill lane 2 to DEPTH with arr_ready=0. Required: in_ready=0 when in_sel=2, in_ready=1 for a non-full lane. Raising arr_ready for one beat restores in_ready for lane 2 and cnt[2]=3.
- Simultaneous load and shift on a lane with cnt=2. Required: cnt stays 2, fifo_load and fifo_shift both asserted that cycle.
- Writes to a finished lane: offer in_sel=1 after lane 1's end has been accepted. Required: in_ready=0, fifo_load=0, no data lost when lane-1 traffic resumes in the next pass.
- Reset mid-DRAIN with cnt nonzero. Required: all outputs at reset values next cycle. A following start/pass behaves as from power-up.
